// File: rtl/riscv_lsu_pkg.sv
// Shared funct3 encodings and FSM state type for the RV32I load/store unit.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StReq   = 2'b01,
        StWaitR = 2'b10,
        StDone  = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store mask/data replication, load extraction/extension, misalign detect.
// LSU_MISALIGN_TRAP_EN enables misalignment detection; otherwise o_misaligned is tied low.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_req_funct3,
    input  logic [1:0]  i_req_addr_lo,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_value,
    output logic        o_misaligned
);

    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;

    assign w_byte_sh = i_rdata >> {i_addr_lo, 3'b000};
    assign w_half_sh = i_rdata >> {i_addr_lo[1], 4'b0000};

    always_comb begin
        o_wmask      = 4'b1111;
        o_wdata      = i_store_data;
        o_load_value = i_rdata;
        unique case (i_funct3[1:0])
            F3_LB[1:0]: begin
                o_wmask      = 4'b0001 << i_addr_lo;
                o_wdata      = {4{i_store_data[7:0]}};
                o_load_value = i_funct3[2] ? {24'b0, w_byte_sh[7:0]}
                                           : {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            end
            F3_LH[1:0]: begin
                o_wmask      = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata      = {2{i_store_data[15:0]}};
                o_load_value = i_funct3[2] ? {16'b0, w_half_sh[15:0]}
                                           : {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            end
            default: begin
            end
        endcase
    end

    // Detection looks at the live request so the FSM can skip the memory access entirely.
`ifdef LSU_MISALIGN_TRAP_EN
    assign o_misaligned = ((i_req_funct3[1:0] == F3_LH[1:0]) && i_req_addr_lo[0])
                        || (i_req_funct3[1] && (i_req_addr_lo != 2'b00));
`else
    logic w_unused;
    assign w_unused     = ^{i_req_funct3, i_req_addr_lo};
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between EXECUTE and the shared memory port (valid/ready request, rvalid data).
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word requests complete without memory access.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_start,
    input  logic                 i_is_load,
    input  logic                 i_is_store,
    input  logic [2:0]           i_funct3,
    input  logic [31:0]          i_addr,
    input  logic [31:0]          i_store_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [31:0]          o_load_data,
    output logic                 o_misaligned,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic                 o_mem_valid,
    input  logic                 i_mem_ready,
    output logic                 o_mem_we,
    output logic [3:0]           o_mem_wmask,
    output logic [31:0]          o_mem_wdata,
    input  logic [31:0]          i_mem_rdata,
    input  logic                 i_mem_rvalid
);

    lsu_state_e           r_state;
    lsu_state_e           w_state_next;
    logic                 r_is_load;
    logic                 r_is_store;
    logic [2:0]           r_funct3;
    logic [ADDR_BITS-1:0] r_addr;
    logic [31:0]          r_store_data;
    logic [31:0]          r_load_data;
    logic                 w_accept;
    logic                 w_access;
    logic                 w_mis;
    logic [3:0]           w_wmask;
    logic [31:0]          w_load_value;

    assign w_accept = (r_state == StIdle) && i_start;
    assign w_access = i_is_load || i_is_store;

    riscv_lsu_align u_align (
        .i_funct3      (r_funct3),
        .i_addr_lo     (r_addr[1:0]),
        .i_store_data  (r_store_data),
        .i_rdata       (i_mem_rdata),
        .i_req_funct3  (i_funct3),
        .i_req_addr_lo (i_addr[1:0]),
        .o_wmask       (w_wmask),
        .o_wdata       (o_mem_wdata),
        .o_load_value  (w_load_value),
        .o_misaligned  (w_mis)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = (w_access && !w_mis) ? StReq : StDone;
                end
            end
            StReq: begin
                if (i_mem_ready) begin
                    w_state_next = r_is_load ? StWaitR : StDone;
                end
            end
            StWaitR: begin
                if (i_mem_rvalid) begin
                    w_state_next = StDone;
                end
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != StIdle);
        o_done      = (r_state == StDone);
        o_mem_valid = (r_state == StReq);
        o_mem_we    = o_mem_valid && r_is_store;
        o_mem_wmask = o_mem_we ? w_wmask : 4'b0000;
    end

    // Loads take priority when the core flags both.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_store_data <= 32'b0;
        end else if (w_accept) begin
            r_is_load    <= i_is_load;
            r_is_store   <= i_is_store && !i_is_load;
            r_funct3     <= i_funct3;
            r_addr       <= i_addr[ADDR_BITS-1:0];
            r_store_data <= i_store_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_load_data <= 32'b0;
        end else if ((r_state == StWaitR) && i_mem_rvalid) begin
            r_load_data <= w_load_value;
        end
    end

    assign o_load_data = r_load_data;
    assign o_mem_addr  = {r_addr[ADDR_BITS-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_mis;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_mis <= 1'b0;
        end else if (w_accept) begin
            r_mis <= w_mis && w_access;
        end
    end

    assign o_misaligned = o_done && r_mis;
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: scoreboard of expected completions and memory requests.
module tb_riscv_lsu;

    logic        clk;
    logic        i_resetn;
    logic        i_start;
    logic        i_is_load;
    logic        i_is_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_load_data;
    logic        o_misaligned;
    logic [31:0] o_mem_addr;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic        o_mem_we;
    logic [3:0]  o_mem_wmask;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_rvalid;

    riscv_lsu #(.ADDR_BITS(32)) u_dut (
        .i_clk        (clk),
        .i_resetn     (i_resetn),
        .i_start      (i_start),
        .i_is_load    (i_is_load),
        .i_is_store   (i_is_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_store_data (i_store_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_load_data  (o_load_data),
        .o_misaligned (o_misaligned),
        .o_mem_addr   (o_mem_addr),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .o_mem_we     (o_mem_we),
        .o_mem_wmask  (o_mem_wmask),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_rvalid (i_mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } req_t;

    exp_t        sb_q[$];
    req_t        rq_q[$];
    int          n_total;
    int          n_bad;
    logic [31:0] exp_ld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00: case (a)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            2'b01:   return {sd[15:0], sd[15:0]};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [1:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (f3[1:0] == 2'b01) return a[0];
        if (f3[1]) return a != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic txn(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       input int rdy, input int rv, input bit dbl);
        logic        is_ld;
        logic        is_st;
        logic        mis;
        logic        req;
        int          cyc;
        int          vcnt;
        int          wcnt;
        bit          hs_load;
        bit          got;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic        s_we;
        logic [3:0]  s_mask;
        exp_t        e;
        req_t        r;

        is_ld = ld;
        is_st = st & ~ld;
        mis   = (is_ld | is_st) && m_mis(f3, a[1:0]);
        req   = (is_ld | is_st) && !mis;
        if (is_ld && req) exp_ld = m_load(f3, a[1:0], rd);
        e.ld  = exp_ld;
        e.mis = mis;
        e.lat = !req ? 1 : (is_ld ? 3 + rdy + rv : 2 + rdy);
        sb_q.push_back(e);
        if (req) begin
            r.addr  = {a[31:2], 2'b00};
            r.we    = is_st;
            r.mask  = is_st ? m_mask(f3, a[1:0]) : 4'b0000;
            r.wdata = m_wdata(f3, sd);
            rq_q.push_back(r);
        end

        i_start      = 1'b1;
        i_is_load    = ld;
        i_is_store   = st;
        i_funct3     = f3;
        i_addr       = a;
        i_store_data = sd;
        i_mem_rdata  = rd;
        cyc = 0; vcnt = 0; wcnt = 0; hs_load = 0; got = 0;
        s_addr = '0; s_wdata = '0; s_we = 1'b0; s_mask = '0;

        while (!got && cyc < 64) begin
            if (cyc > 0) check("busy", 32'(o_busy), 32'd1);
            i_mem_rvalid = hs_load && (wcnt >= rv);
            if (hs_load) wcnt++;
            i_mem_ready = 1'b0;
            if (!req) check("no_valid", 32'(o_mem_valid), 32'd0);
            if (req && o_mem_valid) begin
                if (vcnt == 0) begin
                    s_addr = o_mem_addr; s_wdata = o_mem_wdata;
                    s_we = o_mem_we; s_mask = o_mem_wmask;
                end else begin
                    check("stable_addr", o_mem_addr, s_addr);
                    check("stable_we", 32'(o_mem_we), 32'(s_we));
                    check("stable_mask", 32'(o_mem_wmask), 32'(s_mask));
                    check("stable_wdata", o_mem_wdata, s_wdata);
                end
                if (vcnt >= rdy && rq_q.size() > 0) begin
                    i_mem_ready = 1'b1;
                    r = rq_q.pop_front();
                    check("req_addr", o_mem_addr, r.addr);
                    check("req_we", 32'(o_mem_we), 32'(r.we));
                    check("req_mask", 32'(o_mem_wmask), 32'(r.mask));
                    if (r.we) check("req_wdata", o_mem_wdata, r.wdata);
                    hs_load = is_ld;
                end
                vcnt++;
            end
            if (o_done && sb_q.size() > 0) begin
                got = 1;
                e = sb_q.pop_front();
                check("load_data", o_load_data, e.ld);
                check("misaligned", 32'(o_misaligned), 32'(e.mis));
                check("latency", cyc, e.lat);
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                i_start      = dbl;
                i_is_load    = dbl ? 1'b0 : 1'($urandom_range(0, 1));
                i_is_store   = dbl ? 1'b1 : 1'($urandom_range(0, 1));
                i_funct3     = dbl ? 3'b010 : 3'($urandom);
                i_addr       = dbl ? 32'h0000_03FC : $urandom;
                i_store_data = dbl ? 32'hDEAD_BEEF : $urandom;
            end else if (cyc == 2) begin
                i_start = 1'b0;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (!got) begin
            sb_q.delete();
            rq_q.delete();
        end
        i_start      = 1'b0;
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        check("busy_after", 32'(o_busy), 32'd0);
        check("done_after", 32'(o_done), 32'd0);
        if (dbl) begin
            repeat (3) begin
                @(posedge clk); #1;
                check("dbl_valid", 32'(o_mem_valid), 32'd0);
                check("dbl_done", 32'(o_done), 32'd0);
            end
        end
    endtask

    logic [2:0] f3s [5];

    initial begin
        n_total = 0; n_bad = 0; exp_ld = 32'h0;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        i_resetn = 1'b0; i_start = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        i_funct3 = 3'b0; i_addr = 32'h0; i_store_data = 32'h0;
        i_mem_ready = 1'b0; i_mem_rdata = 32'h0; i_mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_valid", 32'(o_mem_valid), 32'd0);
        check("rst_we", 32'(o_mem_we), 32'd0);
        check("rst_wmask", 32'(o_mem_wmask), 32'd0);
        check("rst_load_data", o_load_data, 32'h0);
        check("rst_mis", 32'(o_misaligned), 32'd0);
        i_resetn = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0, 0);
        txn(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h12F0_3456, 0, 0, 0);
        check("lb_val", o_load_data, 32'hFFFF_FFF0);
        txn(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h12F0_3456, 0, 0, 0);
        check("lbu_val", o_load_data, 32'h0000_00F0);
        txn(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 3, 2, 0);
        check("lh_val", o_load_data, 32'hFFFF_8001);
        txn(1'b0, 1'b1, 3'b001, 32'h0000_00FE, 32'h1234_BEEF, 32'h0, 1, 0, 0);
        txn(1'b0, 1'b0, 3'b010, 32'h0000_0010, 32'h5555_5555, 32'h0, 0, 0, 0);
        txn(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
        txn(1'b1, 1'b0, 3'b101, 32'h0000_0201, 32'h0, 32'hA5A5_8421, 0, 1, 0);
        txn(1'b1, 1'b1, 3'b000, 32'h0000_0021, 32'h0000_0077, 32'h0000_9900, 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3s[$urandom_range(0, 4)],
                $urandom & 32'h0000_0FFF, $urandom, $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
        end

        txn(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h89AB_CDEF, 1, 0, 1);

        // Abort a load parked in WAIT_R.
        i_start = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b001;
        i_addr = 32'h0000_0202; i_mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("abort_w_valid_pre", 32'(o_mem_valid), 32'd1);
        i_mem_ready = 1'b1;
        @(posedge clk); #1;
        i_mem_ready = 1'b0;
        check("abort_w_busy_pre", 32'(o_busy), 32'd1);
        check("abort_w_ld_pre", o_load_data, exp_ld);
        i_resetn = 1'b0;
        #1;
        check("abort_w_valid", 32'(o_mem_valid), 32'd0);
        check("abort_w_busy", 32'(o_busy), 32'd0);
        check("abort_w_ld", o_load_data, 32'h0);
        check("abort_w_done", 32'(o_done), 32'd0);
        #2 i_resetn = 1'b1;
        exp_ld = 32'h0;
        sb_q.delete();
        rq_q.delete();
        @(posedge clk); #1;

        // Abort during REQ: mem_valid must drop without a clock edge.
        i_start = 1'b1; i_is_load = 1'b0; i_is_store = 1'b1; i_funct3 = 3'b010;
        i_addr = 32'h0000_0300; i_store_data = 32'h0BAD_F00D;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("abort_r_valid_pre", 32'(o_mem_valid), 32'd1);
        i_resetn = 1'b0;
        #1;
        check("abort_r_valid", 32'(o_mem_valid), 32'd0);
        check("abort_r_we", 32'(o_mem_we), 32'd0);
        check("abort_r_wmask", 32'(o_mem_wmask), 32'd0);
        #2 i_resetn = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 1'b1, 3'b010, 32'h0000_0080, 32'hFEED_5678, 32'h0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit for the multicycle RV32I core.
- Sits between the core's EXECUTE stage and the shared instruction/data memory port.
- Takes an effective address, funct3 and rs2 data from the core. Drives a valid/ready memory request with byte write mask, then returns sign- or zero-extended load data.
- The core stalls in a WAIT_DATA state while busy is high.

Parameters:
- ADDR_BITS, 32, width of mem_addr (upper address bits beyond this are dropped).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse from core.
- is_load  in  1  request is LB/LH/LW/LBU/LHU.
- is_store  in  1  request is SB/SH/SW.
- funct3  in  3  instruction funct3.
- addr  in  32  byte effective address (rs1+imm).
- store_data  in  32  rs2 value.
- busy  out  1  high from accepted start until done cycle inclusive.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result, valid when done is high, held afterwards.
- misaligned  out  1  qualified by done (see Optional Feature).
- mem_addr  out  ADDR_BITS  word-aligned byte address ({addr[..:2],2'b00}).
- mem_valid  out  1  request valid.
- mem_ready  in  1  memory accepts request.
- mem_we  out  1  1=write.
- mem_wmask  out  4  byte enables.
- mem_wdata  out  32  replicated store data.
- mem_rdata  in  32  read word.
- mem_rvalid  in  1  read data valid.

Behaviour:
- Reset (async, resetn low): state=IDLE. busy, done, misaligned, mem_valid, mem_we are 0. mem_wmask=0, load_data=0. Reset mid-transaction aborts immediately; mem_valid drops asynchronously.
- States: IDLE, REQ, WAIT_R, DONE (2-bit encoding).
- IDLE, start=1:
  - Latch addr, funct3, store_data, is_load, is_store.
  - is_load wins if both are set.
  - If neither is set, go to DONE with no memory access.
  - Otherwise go to REQ.
  - start is ignored outside IDLE.
- REQ: mem_valid=1. mem_addr/mem_we/mem_wmask/mem_wdata are stable until handshake. On mem_valid&&mem_ready: store goes to DONE, load goes to WAIT_R. mem_valid deasserts in the next cycle.
- WAIT_R: on mem_rvalid, capture the extracted value into load_data and go to DONE. mem_rvalid is ignored in all other states.
- DONE: done=1 for exactly one cycle, then IDLE. busy deasserts in the cycle after DONE.
- Latency with a zero-wait memory (ready and rvalid high): store done at start+2 cycles; load done at start+3 cycles.
- Write mask by funct3[1:0]:
  - 00: wmask = 4'b0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
  - 01: wmask = 4'b0011 << {addr[1],1'b0}; wdata = {2{sd[15:0]}}.
  - 10 or 11: wmask = 4'b1111; wdata = sd.
  - Loads drive wmask=0, mem_we=0.
- Load extraction:
  - Byte = rdata >> (8*addr[1:0]); halfword = rdata >> (16*addr[1]).
  - funct3[2]=0 sign-extends, 1 zero-extends. Word passes through.
- load_data keeps its last value across stores and no-op requests.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - A misaligned request goes IDLE to DONE with no memory request and misaligned=1 during the done cycle; load_data is unchanged.
- Undefined:
  - misaligned is tied 0.
  - Offending low bits are ignored: halfword uses addr[1] only, word uses neither.

Decomposition:
- Package riscv_lsu_pkg:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - State encodings.
- Sub-module riscv_lsu_align (combinational), containing:
  - wmask/wdata generation.
  - Load byte/half extraction and extension.
  - Misalignment detect.

Test Plan:
- SB addr=0x103, sd=0x000000A5, zero-wait memory -> mem_wmask=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100, done 2 cycles after start.
- LB addr=0x102, rdata=0x12F03456 -> load_data=0xFFFFFFF0. Same word with LBU -> load_data=0x000000F0.
- LH addr=0x202, rdata=0x80017FFF, with mem_ready delayed 3 cycles and rvalid 2 cycles later -> mem_valid and request fields stable throughout, load_data=0xFFFF8001, busy high all the way, done single pulse.
- LW addr=0x006 with LSU_MISALIGN_TRAP_EN -> no mem_valid, done+misaligned at start+1, load_data unchanged. Without the macro -> word read at 0x004.
- Reset asserted while in WAIT_R -> mem_valid=0, busy=0, load_data=0 immediately. A subsequent SW after release completes normally. A second start pulse issued while busy -> ignored.
